// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared FSM state type and counter sizing for the shift-add multiplier
package seq_mul_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction
endpackage

// File: rtl/seq_mul_ctrl.sv
// seq_mul_ctrl: handshake FSM and iteration counter for the shift-add multiplier
// Ports: clk, rst (async, active-high), in_valid/in_ready, out_valid/out_ready,
//        busy (RUN or DONE), load (operand accept), step (one iteration this cycle)
module seq_mul_ctrl
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic out_ready,
   output logic in_ready,
   output logic out_valid,
   output logic busy,
   output logic load,
   output logic step
);
   localparam int CW = cnt_width(WIDTH);
   state_e state, state_n;
   logic [CW-1:0] cnt;
   logic last;
   // in_ready is a pure state decode, forced low while reset is held
   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = state == DONE;
   assign busy      = state != IDLE;
   assign step      = state == RUN;
   assign load      = in_valid && in_ready;
   assign last      = cnt == CW'(WIDTH - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_n;
   always_comb begin
      state_n = state;
      if (state == IDLE && load)      state_n = RUN;
      if (state == RUN && last)       state_n = DONE;
      if (state == DONE && out_ready) state_n = IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst)       cnt <= '0;
      else if (load) cnt <= '0;
      else if (step) cnt <= cnt + 1'b1;
endmodule

// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: multi-cycle unsigned shift-add multiplier, one multiplier bit per clock
// Ports: clk, rst (async, active-high), in_valid/in_ready/in_a/in_b operand handshake,
//        out_valid/out_ready/out_product result handshake, busy (RUN or DONE).
// SEQ_MUL_SIGNED_EN: adds in_signed; signed operands are multiplied as magnitudes
//        and the product is negated combinationally in DONE.
module seq_shift_add_multiplier
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
`ifdef SEQ_MUL_SIGNED_EN
   input  logic               in_signed,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_product,
   output logic               busy
);
   logic [WIDTH-1:0]   a_q, a_in, b_in, sum;
   logic [2*WIDTH-1:0] p_q;
   logic               co, load, step;
   seq_mul_ctrl #(.WIDTH(WIDTH)) u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .out_ready (out_ready),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .busy      (busy),
      .load      (load),
      .step      (step)
   );
   // WIDTH-bit adder with carry-in 0: accumulator upper half plus gated multiplicand
   assign {co, sum} = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, p_q[0] ? a_q : '0};
`ifdef SEQ_MUL_SIGNED_EN
   logic neg_q, neg_in;
   assign neg_in      = in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
   // the most-negative value maps to itself, which is its correct unsigned magnitude
   assign a_in        = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
   assign b_in        = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
   assign out_product = (neg_q && out_valid) ? -p_q : p_q;
   always_ff @(posedge clk or posedge rst)
      if (rst)       neg_q <= 1'b0;
      else if (load) neg_q <= neg_in;
`else
   assign a_in        = in_a;
   assign b_in        = in_b;
   assign out_product = p_q;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         a_q <= '0;
         p_q <= '0;
      end else if (load) begin
         a_q <= a_in;
         p_q <= {{WIDTH{1'b0}}, b_in};
      end else if (step) begin
         p_q <= {co, sum, p_q[WIDTH-1:1]};
      end
endmodule
